// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered Rijndael ShiftRows / InvShiftRows stage for
// NB = 4, 6 or 8 state columns. The row shift is applied combinationally on
// the input side; the result lands in a 2-entry buffer (head A, skid B) so
// that in_ready comes straight from a flop.
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [0:32*NB-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:32*NB-1] out_data
);

  localparam int DATA_W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Rijndael row offset; only the 256-bit block widens rows 2 and 3.
  function automatic int row_offset(input int r);
    int off;
    case (r)
      0:       off = 0;
      1:       off = 1;
      2:       off = (NB == 8) ? 3 : 2;
      default: off = (NB == 8) ? 4 : 3;
    endcase
    return off;
  endfunction

  // Byte s[r][c] sits at byte index 4c+r, MSB-first.
  function automatic logic [0:DATA_W-1] shift_rows(input logic [0:DATA_W-1] d,
                                                   input logic              inv);
    logic [0:DATA_W-1] o;
    int                src;
    int                off;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      off = row_offset(r);
      for (int c = 0; c < NB; c++) begin
        src = inv ? ((c - off + NB) % NB) : ((c + off) % NB);
        o[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  logic [0:DATA_W-1] shifted_p0;
  logic [0:DATA_W-1] slot_a_p1;
  logic [0:DATA_W-1] slot_b_p1;
  logic [1:0]        count_p1;
  logic [1:0]        count_nxt;
  logic              in_ready_p1;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_a;
  logic              load_b;
  logic              pop_b;

  // ---- stage p0: combinational row shift, mode taken with the data ----
  assign shifted_p0 = shift_rows(in_data, in_inv);

  assign in_xfer  = in_valid && in_ready_p1;
  assign out_xfer = (count_p1 != 2'd0) && out_ready;

  // A takes a new beat when it is (or is about to become) the only entry;
  // B only fills when A stays occupied; a pop from full promotes B into A.
  assign load_a = in_xfer && ((count_p1 == 2'd0) || ((count_p1 == 2'd1) && out_xfer));
  assign load_b = in_xfer && (count_p1 == 2'd1) && !out_xfer;
  assign pop_b  = out_xfer && (count_p1 == 2'd2);

  // Next occupancy: push and pop together leave the count unchanged.
  always_comb begin
    count_nxt = count_p1;
    case ({in_xfer, out_xfer})
      2'b10:   count_nxt = count_p1 + 2'd1;
      2'b01:   count_nxt = count_p1 - 2'd1;
      default: count_nxt = count_p1;
    endcase
  end

  // ---- stage p1: buffer occupancy and registered in_ready ----
  // Occupancy and in_ready advance together so in_ready never admits a third beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p1    <= 2'd0;
      in_ready_p1 <= 1'b1;
    end else begin
      count_p1    <= count_nxt;
      in_ready_p1 <= (count_nxt != 2'd2);
    end
  end

  // Head slot; cleared on reset so the output bus reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_a_p1 <= '0;
    end else if (load_a) begin
      slot_a_p1 <= shifted_p0;
    end else if (pop_b) begin
      slot_a_p1 <= slot_b_p1;
    end
  end

  // Skid slot; its contents are only meaningful while the count is 2.
  always_ff @(posedge clk) begin
    if (load_b) begin
      slot_b_p1 <= shifted_p0;
    end
  end

  assign in_ready  = in_ready_p1;
  assign out_valid = (count_p1 != 2'd0);
  assign out_data  = slot_a_p1;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Testbench for shift_rows_pipe: NB = 4 directed, streaming, backpressure and
// reset scenarios, plus NB = 6 and NB = 8 forward/inverse vectors.
module tb_shift_rows_pipe;

  logic clk;
  logic rst_n;

  logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [0:127] in_data4, out_data4;
  logic         in_valid6, in_ready6, in_inv6, out_valid6, out_ready6;
  logic [0:191] in_data6, out_data6;
  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [0:255] in_data8, out_data8;

  logic [0:127] q4[$];
  logic [0:191] q6[$];
  logic [0:255] q8[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic         hold4 = 1'b0;
  logic [0:127] held4 = '0;

  localparam logic [0:127] VA  = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [0:127] VB  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [0:127] AS4 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] F4  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [0:127] I4  = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [0:191] AS6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [0:191] F6  = 192'h00050a0f04090e13080d12170c11160310150207 * 0 +
                                 192'h00050a0f04090e13080d12170c111603101502071401060b;
  localparam logic [0:255] AS8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:255] F8  = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
  );

  shift_rows_pipe #(.NB(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_inv(in_inv6), .in_data(in_data6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6)
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference NB=4 model: rotate each row one byte at a time, r times.
  function automatic logic [0:127] model4(input logic [0:127] d, input bit inv);
    logic [7:0]   st[4][4];
    logic [7:0]   t;
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[8*(4*c+r) +: 8];
    for (int r = 1; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        if (!inv) begin
          t = st[r][0];
          for (int c = 0; c < 3; c++) st[r][c] = st[r][c+1];
          st[r][3] = t;
        end else begin
          t = st[r][3];
          for (int c = 3; c > 0; c--) st[r][c] = st[r][c-1];
          st[r][0] = t;
        end
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = st[r][c];
    return o;
  endfunction

  // Offer one beat to the NB=4 instance; the expectation is queued at the accept.
  task automatic send4(input logic [0:127] d, input logic inv, input logic [0:127] e);
    bit done;
    done      = 1'b0;
    in_valid4 = 1'b1;
    in_data4  = d;
    in_inv4   = inv;
    for (int i = 0; i < 32 && !done; i++) begin
      if (in_ready4) begin
        q4.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    in_valid4 = 1'b0;
    if (!done) chk("nb4_accept_timeout", in_ready4, 1);
  endtask

  // NB=4 monitor: pops on every output transfer and checks hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold4) begin
        chk("nb4_stall_valid", out_valid4, 1);
        chk("nb4_stall_data", out_data4, held4);
      end
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) chk("nb4_unexpected_out", out_valid4, 0);
        else chk("nb4_out", out_data4, q4.pop_front());
      end
    end
    hold4 <= rst_n && out_valid4 && !out_ready4;
    held4 <= out_data4;
  end

  // NB=6 monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid6 && out_ready6) begin
      if (q6.size() == 0) chk("nb6_unexpected_out", out_valid6, 0);
      else chk("nb6_out", out_data6, q6.pop_front());
    end
  end

  // NB=8 monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) chk("nb8_unexpected_out", out_valid8, 0);
      else chk("nb8_out", out_data8, q8.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:127] d;
    bit           inv;

    rst_n = 1'b0;
    in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
    in_valid6 = 1'b0; in_inv6 = 1'b0; in_data6 = '0; out_ready6 = 1'b1;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    tick();
    tick();
    chk("reset_out_valid", out_valid4, 0);
    chk("reset_in_ready", in_ready4, 1);
    chk("reset_out_data", out_data4, 0);
    chk("reset_out_valid8", out_valid8, 0);
    rst_n = 1'b1;
    tick();

    // Single forward beat: 1-cycle latency, valid for exactly one cycle.
    send4(VA, 1'b0, VB);
    chk("fwd_valid", out_valid4, 1);
    chk("fwd_data", out_data4, VB);
    tick();
    chk("fwd_valid_one_cycle", out_valid4, 0);
    chk("empty_holds_data", out_data4, VB);

    // Single inverse beat.
    send4(VB, 1'b1, VA);
    chk("inv_data", out_data4, VA);
    tick();

    // Back-to-back stream with alternating mode.
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k * 17 + i * 29 + 3);
      inv = (i % 2) == 1;
      chk("stream_in_ready", in_ready4, 1);
      send4(d, inv, model4(d, inv));
    end
    tick();
    tick();
    chk("stream_drained", out_valid4, 0);

    // Backpressure: three beats offered with out_ready low.
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_inv4 = 1'b0; in_data4 = AS4;
    chk("bp_ready0", in_ready4, 1);
    q4.push_back(F4);
    tick();
    in_inv4 = 1'b1; in_data4 = AS4;
    chk("bp_ready1", in_ready4, 1);
    chk("bp_valid1", out_valid4, 1);
    chk("bp_head1", out_data4, F4);
    q4.push_back(I4);
    tick();
    in_inv4 = 1'b0; in_data4 = VA;
    chk("bp_full_ready", in_ready4, 0);
    chk("bp_head2", out_data4, F4);
    tick();
    tick();
    chk("bp_still_full", in_ready4, 0);
    chk("bp_head3", out_data4, F4);
    out_ready4 = 1'b1;
    tick();
    chk("bp_ready_after_pop", in_ready4, 1);
    chk("bp_second", out_data4, I4);
    q4.push_back(VB);
    tick();
    in_valid4 = 1'b0;
    chk("bp_third", out_data4, VB);
    chk("bp_third_valid", out_valid4, 1);
    tick();
    chk("bp_drained", out_valid4, 0);

    // NB=8 and NB=6: forward of ascending bytes, then inverse of that result.
    in_valid8 = 1'b1; in_inv8 = 1'b0; in_data8 = AS8;
    in_valid6 = 1'b1; in_inv6 = 1'b0; in_data6 = AS6;
    chk("nb8_ready", in_ready8, 1);
    chk("nb6_ready", in_ready6, 1);
    q8.push_back(F8);
    q6.push_back(F6);
    tick();
    chk("nb8_col0", out_data8[0:31], 32'h00050e13);
    chk("nb6_col0", out_data6[0:31], 32'h00050a0f);
    in_inv8 = 1'b1; in_data8 = F8;
    in_inv6 = 1'b1; in_data6 = F6;
    q8.push_back(AS8);
    q6.push_back(AS6);
    tick();
    in_valid8 = 1'b0;
    in_valid6 = 1'b0;
    chk("nb8_inv_restores", out_data8, AS8);
    chk("nb6_inv_restores", out_data6, AS6);
    tick();

    // Reset with two beats buffered; inputs offered during reset are ignored.
    out_ready4 = 1'b0;
    send4(VA, 1'b0, VB);
    send4(VB, 1'b1, VA);
    chk("pre_reset_full", in_ready4, 0);
    rst_n = 1'b0;
    in_valid4 = 1'b1; in_data4 = AS4; in_inv4 = 1'b0;
    tick();
    q4.delete();
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_in_ready", in_ready4, 1);
    chk("rst_out_data", out_data4, 0);
    rst_n = 1'b1;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    tick();
    chk("post_rst_idle", out_valid4, 0);
    send4(AS4, 1'b0, F4);
    chk("post_rst_valid", out_valid4, 1);
    chk("post_rst_data", out_data4, F4);
    tick();
    tick();

    chk("q4_empty", q4.size(), 0);
    chk("q6_empty", q6.size(), 0);
    chk("q8_empty", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, registered successor to the combinational AES shift_rows stage. Supports Rijndael block widths of NB = 4, 6 or 8 columns.
- A per-transaction mode bit selects forward ShiftRows or InvShiftRows.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is a registered signal.
- Sits between sub_bytes and mix_columns in the round datapath, on both the encrypt and decrypt paths.

Parameters:
- NB, 4: state columns. Legal values are 4, 6 and 8; any other value is an elaboration error via a generate-time check. Block width W = 32*NB.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
- in_data  input  [0:W-1]  state, byte k = in_data[8k:8k+7]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_data  output  [0:W-1]  shifted state, same byte ordering

Behaviour:
- Bit order: MSB-first vector [0:W-1]. State byte s[r][c] = byte 4c+r (column-major), r = 0..3, c = 0..NB-1.
- Row offsets (C0,C1,C2,C3):
  - NB = 4 or 6: (0,1,2,3)
  - NB = 8: (0,1,3,4)
- Forward transform: out s[r][c] = in s[r][(c+Cr) mod NB].
- Inverse transform: out s[r][c] = in s[r][(c-Cr+NB) mod NB].
- The mode bit is per beat. Consecutive beats may alternate modes with no bubble.
- Transform is combinational on the input side. The result is stored in a 2-entry buffer (slot A = head, slot B = skid); in_inv is not stored.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: 1 cycle. A beat accepted at edge N is presented on out_data after edge N when the buffer was empty.
- Occupancy count: 0, 1 or 2 entries.
  - in_ready (registered) = (count < 2) at the next edge. Concretely, in_ready is deasserted the cycle after count reaches 2.
  - out_valid = (count != 0).
  - out_data = slot A.
- Simultaneous input and output transfer: count is unchanged. The new beat goes behind the remaining entry. When count = 1, A is reloaded with the new beat.
- Full (count = 2):
  - in_valid is ignored; no overwrite.
  - An output pop moves B to A, and in_ready rises the following cycle.
- Empty: out_data holds its last value; out_valid = 0.
- Throughput: one beat per cycle sustained while out_ready = 1. out_ready low for k cycles stalls the input after at most 2 accepted beats.
- Reset: when rst_n = 0 at a clock edge:
  - count clears to 0, out_valid = 0, in_ready = 1 after that edge, out_data = 0.
  - Any in-flight beats are discarded.
  - Inputs are ignored during reset.
- out_data and out_valid must not change while out_valid && !out_ready (AXI-style stability).

Test Plan:
- NB = 4, forward, in 63cab7040953d051cd60e0e7ba70e18c, out_ready = 1 -> out_data 6353e08c0960e104cd70b751bacad0e7 one cycle later, out_valid for exactly 1 cycle.
- NB = 4, inverse, in 6353e08c0960e104cd70b751bacad0e7 -> 63cab7040953d051cd60e0e7ba70e18c.
- Back-to-back stream, alternating in_inv every beat, 9 beats, out_ready = 1 -> 9 outputs in order, in_ready never drops, each output matches a software model.
- Backpressure: out_ready = 0 while 3 beats are offered -> exactly 2 accepted, in_ready low from the cycle after the 2nd accept. out_data stable at beat 0. Releasing out_ready drains beats 0, 1, then accepts beat 2.
- NB = 8, forward, in_data = bytes 00..1f ascending -> row 2 shifted by 3 and row 3 by 4. Out column 0 = 00 05 0e 13. Inverse of that output restores the input. Also run NB = 6: out column 0 = 00 05 0a 0f.
- rst_n = 0 with 2 beats buffered -> next cycle out_valid = 0, in_ready = 1, out_data = 0. A post-reset beat emerges with 1-cycle latency.
